// File: rtl/bpi_cmd_fifo.sv
// Command FIFO between the VME BPI port decoder and the command parser.
// Block-RAM storage with a one-deep read stage and a first-word-fall-through head register.
module bpi_cmd_fifo #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WIDTH      = 16
) (
  input  logic                  CLK,
  input  logic                  RST_B,
  input  logic                  BPI_RST,
  input  logic                  BPI_WE,
  input  logic [WIDTH-1:0]      BPI_CMD_FIFO_DATA,
  input  logic                  BPI_DSBL,
  input  logic                  BPI_ENBL,
  input  logic                  CMD_ACK,
  output logic [WIDTH-1:0]      CMD_DATA,
  output logic                  CMD_VALID,
  output logic                  PARSE_EN,
  output logic [DEPTH_LOG2:0]   WRD_CNT,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  OVERFLOW
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [WIDTH-1:0]      ram_q;
  logic                  ram_v;
  logic                  head_v;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   wrd_cnt;
  logic [DEPTH_LOG2:0]   ram_cnt;
  logic                  full;
  logic                  wr_ok;
  logic                  pop;
  logic                  ram_move;
  logic                  rd_en;

  // Handshake: the head word transfers on a rising edge where CMD_VALID=1 and
  // CMD_ACK=1; the ack is discarded if BPI_DSBL or BPI_RST is high in that cycle.
  always_comb begin
    full     = (wrd_cnt == DEPTH_CNT);
    wr_ok    = BPI_WE && !full && !BPI_RST;
    pop      = head_v && PARSE_EN && CMD_ACK && !BPI_DSBL && !BPI_RST;
    // Words still sitting in RAM, not yet in the read stage or head register.
    ram_cnt  = wrd_cnt - {{DEPTH_LOG2{1'b0}}, head_v} - {{DEPTH_LOG2{1'b0}}, ram_v};
    ram_move = ram_v && (!head_v || pop);
    rd_en    = (ram_cnt != '0) && (!ram_v || ram_move) && !BPI_RST;
  end

  // RAM array and its registered read port; no reset so it maps to block RAM.
  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wr_ptr] <= BPI_CMD_FIFO_DATA;
    if (rd_en) ram_q <= mem[rd_ptr];
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wrd_cnt  <= '0;
      ram_v    <= 1'b0;
      head_v   <= 1'b0;
      CMD_DATA <= '0;
      OVERFLOW <= 1'b0;
      PARSE_EN <= 1'b1;
    end else begin
      if (BPI_DSBL)      PARSE_EN <= 1'b0;
      else if (BPI_ENBL) PARSE_EN <= 1'b1;

      if (BPI_RST) begin
        // Flush leaves CMD_DATA showing its last value.
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        wrd_cnt  <= '0;
        ram_v    <= 1'b0;
        head_v   <= 1'b0;
        OVERFLOW <= 1'b0;
      end else begin
        if (wr_ok)          wr_ptr   <= wr_ptr + PTR_ONE;
        if (BPI_WE && full) OVERFLOW <= 1'b1;
        if (rd_en)          rd_ptr   <= rd_ptr + PTR_ONE;

        case ({wr_ok, pop})
          2'b10:   wrd_cnt <= wrd_cnt + CNT_ONE;
          2'b01:   wrd_cnt <= wrd_cnt - CNT_ONE;
          default: wrd_cnt <= wrd_cnt;
        endcase

        if (rd_en)         ram_v <= 1'b1;
        else if (ram_move) ram_v <= 1'b0;

        if (ram_move) begin
          head_v   <= 1'b1;
          CMD_DATA <= ram_q;
        end else if (pop) begin
          head_v   <= 1'b0;
        end
      end
    end
  end

  assign CMD_VALID = head_v && PARSE_EN;
  assign WRD_CNT   = wrd_cnt;
  assign EMPTY     = (wrd_cnt == '0);
  assign FULL      = full;

endmodule

// File: tb/tb_bpi_cmd_fifo.sv
// Bench for bpi_cmd_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_bpi_cmd_fifo;

  localparam int DEPTH_LOG2 = 10;
  localparam int WIDTH      = 16;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                CLK;
  logic                RST_B;
  logic                BPI_RST;
  logic                BPI_WE;
  logic [WIDTH-1:0]    BPI_CMD_FIFO_DATA;
  logic                BPI_DSBL;
  logic                BPI_ENBL;
  logic                CMD_ACK;
  logic [WIDTH-1:0]    CMD_DATA;
  logic                CMD_VALID;
  logic                PARSE_EN;
  logic [DEPTH_LOG2:0] WRD_CNT;
  logic                EMPTY;
  logic                FULL;
  logic                OVERFLOW;

  bpi_cmd_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST_B(RST_B), .BPI_RST(BPI_RST), .BPI_WE(BPI_WE),
    .BPI_CMD_FIFO_DATA(BPI_CMD_FIFO_DATA), .BPI_DSBL(BPI_DSBL), .BPI_ENBL(BPI_ENBL),
    .CMD_ACK(CMD_ACK), .CMD_DATA(CMD_DATA), .CMD_VALID(CMD_VALID), .PARSE_EN(PARSE_EN),
    .WRD_CNT(WRD_CNT), .EMPTY(EMPTY), .FULL(FULL), .OVERFLOW(OVERFLOW)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  // ---------------- counters / check ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each stored word carries the earliest edge after which it may sit at the head:
  // two edges after its write, and no earlier than the pop of the word before it.
  logic [WIDTH-1:0] exp_q[$];
  int               rdy_q[$];
  int               edge_n = 0;
  logic             m_pen  = 1'b1;
  logic             m_ovf  = 1'b0;
  logic [WIDTH-1:0] m_data = '0;

  always @(posedge CLK) begin
    logic vpre;
    logic full_pre;
    edge_n++;
    if (!RST_B) begin
      exp_q.delete();
      rdy_q.delete();
      m_ovf  = 1'b0;
      m_pen  = 1'b1;
      m_data = '0;
    end else begin
      vpre = m_pen && (exp_q.size() > 0) && (rdy_q[0] <= edge_n - 1);
      if (BPI_RST) begin
        exp_q.delete();
        rdy_q.delete();
        m_ovf = 1'b0;
      end else begin
        full_pre = (exp_q.size() == DEPTH);
        if (vpre && CMD_ACK && !BPI_DSBL) begin
          void'(exp_q.pop_front());
          void'(rdy_q.pop_front());
          if (exp_q.size() > 0 && rdy_q[0] < edge_n) rdy_q[0] = edge_n;
        end
        if (BPI_WE) begin
          if (full_pre) m_ovf = 1'b1;
          else begin
            exp_q.push_back(BPI_CMD_FIFO_DATA);
            rdy_q.push_back(edge_n + 2);
          end
        end
      end
      if (BPI_DSBL)      m_pen = 1'b0;
      else if (BPI_ENBL) m_pen = 1'b1;
    end
    if (exp_q.size() > 0 && rdy_q[0] <= edge_n) m_data = exp_q[0];
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge CLK) begin
    logic ev;
    #1;
    if (chk_en) begin
      ev = m_pen && (exp_q.size() > 0) && (rdy_q[0] <= edge_n);
      check("cmd_valid", 32'(CMD_VALID), 32'(ev));
      check("cmd_data",  32'(CMD_DATA),  32'(m_data));
      check("wrd_cnt",   32'(WRD_CNT),   32'(exp_q.size()));
      check("empty",     32'(EMPTY),     32'(exp_q.size() == 0));
      check("full",      32'(FULL),      32'(exp_q.size() == DEPTH));
      check("overflow",  32'(OVERFLOW),  32'(m_ovf));
      check("parse_en",  32'(PARSE_EN),  32'(m_pen));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wr(input logic [WIDTH-1:0] d);
    BPI_WE = 1'b1;
    BPI_CMD_FIFO_DATA = d;
    @(negedge CLK);
    BPI_WE = 1'b0;
  endtask

  task automatic pulse_dsbl();
    BPI_DSBL = 1'b1;
    @(negedge CLK);
    BPI_DSBL = 1'b0;
  endtask

  task automatic pulse_enbl();
    BPI_ENBL = 1'b1;
    @(negedge CLK);
    BPI_ENBL = 1'b0;
  endtask

  // Holds CMD_ACK until empty; returns count and last word seen.
  task automatic drain(input int budget, output int n, output logic [WIDTH-1:0] last);
    n = 0;
    last = '0;
    CMD_ACK = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (EMPTY) break;
      if (CMD_VALID) begin
        n++;
        last = CMD_DATA;
      end
      @(negedge CLK);
    end
    CMD_ACK = 1'b0;
    check("drain_done", 32'(EMPTY), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int               n;
    int               writes;
    int               r;
    logic [WIDTH-1:0] last;

    RST_B = 1'b0; BPI_RST = 1'b0; BPI_WE = 1'b0; BPI_CMD_FIFO_DATA = '0;
    BPI_DSBL = 1'b0; BPI_ENBL = 1'b0; CMD_ACK = 1'b0;
    idle(3);
    check("rst_cnt",   32'(WRD_CNT),   32'd0);
    check("rst_empty", 32'(EMPTY),     32'd1);
    check("rst_full",  32'(FULL),      32'd0);
    check("rst_valid", 32'(CMD_VALID), 32'd0);
    check("rst_data",  32'(CMD_DATA),  32'd0);
    check("rst_pen",   32'(PARSE_EN),  32'd1);
    check("rst_ovf",   32'(OVERFLOW),  32'd0);
    RST_B = 1'b1;
    chk_en = 1'b1;

    // Reset mid-stream with 5 words stored and parsing disabled
    pulse_dsbl();
    for (int i = 0; i < 5; i++) wr(16'(16'h0050 + i));
    idle(3);
    check("pre_rst_cnt", 32'(WRD_CNT), 32'd5);
    RST_B = 1'b0;
    #1;
    check("mid_rst_cnt",   32'(WRD_CNT),   32'd0);
    check("mid_rst_empty", 32'(EMPTY),     32'd1);
    check("mid_rst_valid", 32'(CMD_VALID), 32'd0);
    check("mid_rst_pen",   32'(PARSE_EN),  32'd1);
    check("mid_rst_ovf",   32'(OVERFLOW),  32'd0);
    idle(2);
    RST_B = 1'b1;
    idle(1);

    // Fill while disabled, then enable with ack held
    pulse_dsbl();
    for (int i = 1; i <= 4; i++) wr(16'(i));
    idle(3);
    check("fill_cnt",   32'(WRD_CNT),   32'd4);
    check("fill_valid", 32'(CMD_VALID), 32'd0);
    BPI_ENBL = 1'b1;
    CMD_ACK  = 1'b1;
    @(negedge CLK);
    BPI_ENBL = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check("seq_valid", 32'(CMD_VALID), 32'd1);
      check("seq_data",  32'(CMD_DATA),  32'(i));
      @(negedge CLK);
    end
    CMD_ACK = 1'b0;
    check("seq_end_valid", 32'(CMD_VALID), 32'd0);
    check("seq_end_empty", 32'(EMPTY),     32'd1);

    // Full and overflow
    for (int i = 0; i < DEPTH; i++) wr(16'(i));
    check("full_flag", 32'(FULL),     32'd1);
    check("full_cnt",  32'(WRD_CNT),  32'd1024);
    check("full_ovf0", 32'(OVERFLOW), 32'd0);
    wr(16'hBEEF);
    check("ovf_set",   32'(OVERFLOW), 32'd1);
    check("ovf_cnt",   32'(WRD_CNT),  32'd1024);
    idle(2);
    CMD_ACK = 1'b1;
    n = 0;
    for (int c = 0; c < DEPTH + 50; c++) begin
      if (EMPTY) break;
      if (CMD_VALID) begin
        check("drain_order", 32'(CMD_DATA), 32'(n));
        n++;
      end
      @(negedge CLK);
    end
    CMD_ACK = 1'b0;
    check("drain_count", 32'(n), 32'd1024);
    idle(2);
    check("no_beef", 32'(CMD_VALID), 32'd0);
    check("ovf_sticky", 32'(OVERFLOW), 32'd1);
    BPI_RST = 1'b1;
    @(negedge CLK);
    BPI_RST = 1'b0;
    check("ovf_clear", 32'(OVERFLOW), 32'd0);

    // Simultaneous write and pop at 3 words
    wr(16'h0010); wr(16'h0011); wr(16'h0012);
    idle(3);
    check("sim_pre_cnt", 32'(WRD_CNT), 32'd3);
    BPI_WE = 1'b1;
    BPI_CMD_FIFO_DATA = 16'h00AA;
    CMD_ACK = 1'b1;
    @(negedge CLK);
    BPI_WE = 1'b0;
    CMD_ACK = 1'b0;
    check("sim_cnt", 32'(WRD_CNT), 32'd3);
    drain(50, n, last);
    check("sim_n",    32'(n),    32'd3);
    check("sim_last", 32'(last), 32'h00AA);

    // Wrap-around with random interleave
    writes = 0;
    for (int c = 0; c < 20000 && writes < 3000; c++) begin
      BPI_WE = (exp_q.size() < 7) && ($urandom_range(0, 3) != 0);
      BPI_CMD_FIFO_DATA = 16'($urandom);
      CMD_ACK = (exp_q.size() > 1) && ($urandom_range(0, 1) == 1);
      r = int'($urandom_range(0, 63));
      BPI_DSBL = (r == 0);
      BPI_ENBL = (r >= 1 && r <= 4);
      @(negedge CLK);
      if (BPI_WE) writes++;
    end
    BPI_WE = 1'b0; CMD_ACK = 1'b0; BPI_DSBL = 1'b0; BPI_ENBL = 1'b0;
    check("wrap_writes", 32'(writes), 32'd3000);
    pulse_enbl();
    drain(100, n, last);

    // Flush collision and enable priority
    wr(16'h0001); wr(16'h0002);
    BPI_RST = 1'b1;
    BPI_WE  = 1'b1;
    BPI_CMD_FIFO_DATA = 16'h1234;
    @(negedge CLK);
    BPI_RST = 1'b0;
    BPI_WE  = 1'b0;
    check("flush_cnt",   32'(WRD_CNT), 32'd0);
    check("flush_empty", 32'(EMPTY),   32'd1);
    idle(4);
    check("flush_novalid", 32'(CMD_VALID), 32'd0);
    BPI_ENBL = 1'b1;
    BPI_DSBL = 1'b1;
    @(negedge CLK);
    BPI_ENBL = 1'b0;
    BPI_DSBL = 1'b0;
    check("prio_pen", 32'(PARSE_EN), 32'd0);
    pulse_enbl();
    check("reenable_pen", 32'(PARSE_EN), 32'd1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
